// File: rtl/niosii_pio_gen_pkg.sv
// niosii_pio_pkg: register map and mode encodings for the parametrised PIO.
package niosii_pio_pkg;
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_LEVEL = 1;
endpackage

// File: rtl/niosii_pio_gen_if.sv
// niosii_pio_gen_if: Avalon-MM slave bus of the PIO (fixed read latency 1).
interface niosii_pio_gen_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/niosii_pio_gen_sync_edge.sv
// niosii_pio_sync_edge: input synchroniser, previous-sample register and armed edge detector.
module niosii_pio_sync_edge
    import niosii_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] i_in,
    output logic [DATA_WIDTH-1:0] o_sync,
    output logic [DATA_WIDTH-1:0] o_edge
);
    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [2:0]            r_cnt;
    logic                  w_armed;
    // Arming waits until the chain has flushed, so pins held high through reset are not captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_prev <= o_sync;
            if (!w_armed) r_cnt <= r_cnt + 3'd1;
        end
    end
    assign w_armed = r_cnt == ARM_CNT;
    assign o_sync  = r_sync[SYNC_STAGES-1];
    assign w_rise  = o_sync & ~r_prev;
    assign w_fall  = ~o_sync & r_prev;
    assign o_edge  = !w_armed ? '0 :
                     EDGE_TYPE == EDGE_RISE ? w_rise :
                     EDGE_TYPE == EDGE_FALL ? w_fall : w_rise | w_fall;
endmodule

// File: rtl/niosii_pio_gen.sv
// niosii_pio_gen: Avalon-MM PIO with per-bit direction, set/clear, edge capture and maskable irq.
module niosii_pio_gen
    import niosii_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          IRQ_MODE    = IRQ_EDGE,
    parameter logic [31:0] RESET_VALUE = '0
)(
    input  logic                  clk,
    input  logic                  reset_n,
    niosii_pio_gen_if.slave       bus,
    input  logic [DATA_WIDTH-1:0] i_in_port,
    output logic [DATA_WIDTH-1:0] o_out_port,
    output logic [DATA_WIDTH-1:0] o_oe_port,
    output logic                  o_irq
);
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_ec;
    logic [31:0]           r_readdata;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_wr;
    logic                  w_rd;

    niosii_pio_sync_edge #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .i_in   (i_in_port),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_rd  = bus.chipselect & ~bus.read_n;
    assign w_wd  = bus.writedata[DATA_WIDTH-1:0];
    assign w_clr = (w_wr && bus.address == ADDR_EDGE) ? w_wd : '0;

    always_comb begin
        w_rdata = bus.address == ADDR_DATA ? (r_out & r_dir) | (w_sync & ~r_dir) :
                  bus.address == ADDR_DIR  ? r_dir :
                  bus.address == ADDR_MASK ? r_mask :
                  bus.address == ADDR_EDGE ? r_ec : '0;
    end

    // A new edge overrides a same-cycle write-1-to-clear on that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out      <= RESET_VALUE[DATA_WIDTH-1:0];
            r_dir      <= '0;
            r_mask     <= '0;
            r_ec       <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_out <= (w_wr && bus.address == ADDR_DATA) ? w_wd :
                     (w_wr && bus.address == ADDR_SET)  ? r_out | w_wd :
                     (w_wr && bus.address == ADDR_CLR)  ? r_out & ~w_wd : r_out;
            if (w_wr && bus.address == ADDR_DIR)  r_dir  <= w_wd;
            if (w_wr && bus.address == ADDR_MASK) r_mask <= w_wd;
            r_ec <= (r_ec & ~w_clr) | w_edge;
            if (w_rd) r_readdata <= 32'(w_rdata);
            r_irq <= IRQ_MODE == IRQ_LEVEL ? |(w_sync & r_mask) : |(r_ec & r_mask);
        end
    end

    assign bus.readdata = r_readdata;
    assign o_out_port   = r_out;
    assign o_oe_port    = r_dir;
    assign o_irq        = r_irq;
endmodule

// File: doc/niosii_pio_gen.md
Name: niosii_pio_gen

Overview:
Parametrised general-purpose Avalon-MM PIO slave for the NIOS II micro system. Successor to the output-only data PIO: configurable width, per-bit direction, atomic set/clear, synchronised inputs with edge capture, and a maskable interrupt. Sits between the system interconnect and board-level pins and sensors; the top level handles tristating through oe_port.

Parameters:
DATA_WIDTH, 32, number of PIO bits (1..32); bits above DATA_WIDTH-1 read as 0, writes to them are ignored.
SYNC_STAGES, 2, input synchroniser depth (2..4).
EDGE_TYPE, 0, edge-capture trigger: 0 rising, 1 falling, 2 any.
IRQ_MODE, 0, interrupt source: 0 edge (edgecapture & irqmask), 1 level (synced input & irqmask).
RESET_VALUE, 0, reset value of the output register (DATA_WIDTH bits).

Ports:
clk  in  1  system clock.
reset_n  in  1  reset, asynchronous, active-low.
address  in  3  word address.
chipselect  in  1  slave select.
write_n  in  1  write strobe, active-low.
read_n  in  1  read strobe, active-low.
writedata  in  32  write data.
readdata  out  32  read data, fixed read latency 1.
in_port  in  DATA_WIDTH  external inputs, asynchronous to clk.
out_port  out  DATA_WIDTH  output register.
oe_port  out  DATA_WIDTH  per-bit output enable (direction register).
irq  out  1  interrupt request, active-high, registered.

Behaviour:
- Strobes: wr = chipselect & ~write_n; rd = chipselect & ~read_n.
- Register map:
  - 0: DATA. Write loads the output register. Read returns, per bit, the output register where direction = 1, else the synced input.
  - 1: DIRECTION. R/W; 1 = output.
  - 2: IRQMASK. R/W.
  - 3: EDGECAPTURE. Read returns captured bits. Write 1 clears that bit; write 0 leaves it unchanged.
  - 4: OUTSET. Write ORs writedata into the output register. Reads as 0.
  - 5: OUTCLEAR. Write clears the output-register bits where writedata = 1. Reads as 0.
  - 6, 7: reserved. Read 0, writes ignored.
- Reset values: output register = RESET_VALUE; direction, irqmask, edgecapture, sync chain, previous-sample register, readdata and irq all 0; arm counter 0.
- Sync: in_port passes through SYNC_STAGES flops to give sync_in; prev_in is sync_in delayed one cycle.
- Edge detect, per bit:
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in; the selected edge term depends on EDGE_TYPE.
  - Detection is gated by an "armed" flag. A counter runs from reset release and sets armed after SYNC_STAGES+1 cycles, so pins held high through reset never produce a spurious capture.
  - Detection is applied to all bits regardless of direction.
- Edgecapture update each cycle: ec <= (ec & ~clr) | edge, where clr = writedata[DATA_WIDTH-1:0] when wr is at address 3, else 0. If a clear and a new edge hit the same bit in the same cycle, the set wins.
- Readdata: registered. If rd is asserted in cycle N, readdata is valid in cycle N+1 and holds until the next rd. A write and a read in the same cycle to the same register return the pre-write value.
- Write side effects become visible in out_port and oe_port one cycle after the write strobe.
- irq is registered: irq <= |(ec & irqmask) in edge mode, or |(sync_in & irqmask) in level mode. An edge at the pin reaches irq SYNC_STAGES+2 cycles later.
- Reset asserted mid-operation clears all state immediately (asynchronous). The arm sequence restarts on release.

Decomposition:
- Package niosii_pio_pkg holds: address constants (ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_SET=4, ADDR_CLR=5), EDGE_RISE/EDGE_FALL/EDGE_ANY, IRQ_EDGE/IRQ_LEVEL.
- One sub-module: niosii_pio_sync_edge. It contains the synchroniser, prev register, arm counter and edge detector, and outputs sync_in and edge.

Test Plan:
- Reset with RESET_VALUE=0x0000_00A5 and in_port=0xFFFF_FFFF held high -> out_port=0xA5, oe_port=0, irq=0. Read of address 3 after 10 cycles returns 0 (no spurious capture).
- Write 0xF0 to address 0, 0x0F to address 4, 0x30 to address 5 -> out_port sequence 0xF0, 0xFF, 0xCF, each visible one cycle after its write.
- Write DIRECTION=0x0000_FFFF, out register=0x1234_5678, in_port=0xABCD_0000 -> read of address 0 returns 0xABCD_5678 on the cycle after rd.
- EDGE_TYPE=0, IRQMASK=0x1: bit 0 of in_port goes 0->1 -> edgecapture bit 0 = 1 and irq rises SYNC_STAGES+2 cycles later. Write 0x1 to address 3 -> irq drops within 2 cycles.
- Simultaneous W1C of bit 0 and a new rising edge on bit 0 in the same cycle -> bit 0 stays 1 and irq stays high.
- IRQ_MODE=1, IRQMASK=0x8: in_port[3] pulses high for 5 cycles -> irq high for 5 cycles, delayed SYNC_STAGES+1. With DATA_WIDTH=8, writing 0xFFFF_FFFF to address 1 reads back 0x0000_00FF.
